dsram_responder: RTL

DSRAM_RESPONDER -- requirements
Module: dsram_responder

---
 rtl/dsram_responder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dsram_responder.sv
// dsram_responder: word-addressed SRAM responder with split address/data
// handshakes and a two-entry in-order response queue.
// A request is accepted in the same cycle as addr_ok. data_ok follows a
// fixed LATENCY cycles later, and responses stay in acceptance order.
// Optional feature macro: DSRAM_RAND_DELAY_EN. When it is defined, an
// LFSR adds 0..3 cycles of extra response delay and random back-pressure.
// ADDR_W must be at most 29, so that the upper address bits exist.
module dsram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         DEPTH  = 1 << ADDR_W;
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  // Storage. Memory contents survive reset.
  logic [31:0] r_mem [DEPTH];

  // Pending queue. Entry 0 is the head, and valid entries are contiguous.
  logic [1:0]  r_vld;
  logic [1:0]  r_wr;
  logic [31:0] r_data [2];
  logic [2:0]  r_cnt [2];

  logic [ADDR_W-1:0] w_idx;
  logic              w_acc;
  logic              w_pop;
  logic              w_slot;
  logic              w_bp_ok;
  logic [2:0]        w_cnt_load;
  logic [2:0]        w_cnt_dec [2];
  logic              w_unused_bits;

  // size only travels with the request. Byte lanes are chosen by wstrb.
  assign w_unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  // Upper address bits are dropped, so out-of-range addresses wrap silently.
  assign w_idx = addr[ADDR_W+1:2];

`ifdef DSRAM_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  logic       w_lfsr_fb;
  logic [3:0] w_cnt_sum;

  // Feedback taps are 8,6,5,4, using 1-based bit numbering.
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_bp_ok    = ~r_lfsr[2];
  assign w_cnt_sum  = {1'b0, LAT_M1} + {2'b00, r_lfsr[1:0]};
  // The countdown is 3 bits wide, so large LATENCY plus jitter saturates at 7.
  assign w_cnt_load = w_cnt_sum[3] ? 3'd7 : w_cnt_sum[2:0];

  // Free-running LFSR, reseeded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end
`else
  assign w_bp_ok    = 1'b1;
  assign w_cnt_load = LAT_M1;
`endif

  // addr_ok uses the pre-pop occupancy. A full queue holds off a new
  // request even in the cycle when the head is popping.
  assign addr_ok = req & ~reset & ~r_vld[1] & w_bp_ok;
  assign w_acc   = addr_ok;
  assign data_ok = r_vld[0] & (r_cnt[0] == 3'd0);
  assign w_pop   = data_ok;
  assign rdata   = (data_ok & ~r_wr[0]) ? r_data[0] : 32'h0;

  // The new entry lands after the surviving entries. Acceptance implies
  // r_vld[1] is 0, so on a pop this selects slot 0.
  assign w_slot = w_pop ? r_vld[1] : r_vld[0];

  // Every valid entry counts down toward zero each cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_cnt_dec[i] = r_cnt[i];
      if (r_vld[i] && (r_cnt[i] != 3'd0)) begin
        w_cnt_dec[i] = r_cnt[i] - 3'd1;
      end
    end
  end

  // Memory write at the accepting edge, merging bytes under wstrb.
  always_ff @(posedge clk) begin
    if (w_acc && wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Queue control: valid bits and countdowns. Reset drops pending responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld    <= 2'b00;
      r_cnt[0] <= 3'd0;
      r_cnt[1] <= 3'd0;
    end else begin
      if (w_pop) begin
        r_vld[0] <= r_vld[1];
        r_cnt[0] <= w_cnt_dec[1];
        r_vld[1] <= 1'b0;
        r_cnt[1] <= 3'd0;
      end else begin
        r_cnt[0] <= w_cnt_dec[0];
        r_cnt[1] <= w_cnt_dec[1];
      end
      if (w_acc) begin
        r_vld[w_slot] <= 1'b1;
        r_cnt[w_slot] <= w_cnt_load;
      end
    end
  end

  // Queue payload: the write flag and the read word, taken from memory before
  // this edge's update. Only one request is accepted per cycle, so there is
  // no same-edge write to forward.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_wr[0]   <= r_wr[1];
      r_data[0] <= r_data[1];
    end
    if (w_acc) begin
      r_wr[w_slot]   <= wr;
      r_data[w_slot] <= r_mem[w_idx];
    end
  end

endmodule
